// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the restoring divider
package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SHIFT  = 3'd2,
    SUB    = 3'd3,
    NOTIFY = 3'd4
  } div_state_t;

endpackage

// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - iteration counter with synchronous clear and enable
module iter_counter #(
  parameter int M = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         en,
  output logic [M-1:0] cnt
);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + M'(1);
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - unsigned sequential restoring divider, one quotient bit per SHIFT/SUB pair
module restoring_divider
  import div_pkg::*;
#(
  parameter  int N = DIV_N,
  localparam int M = $clog2(N) + 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [N-1:0] DIVIDEND,
  input  logic [N-1:0] DIVISOR,
  output logic [N-1:0] QUOTIENT,
  output logic [N-1:0] REMAINDER,
  output logic         BUSY,
  output logic         FINDIV,
  output logic         DIV_ZERO
);

  div_state_t   state;
  div_state_t   state_nxt;
  logic [N:0]   r;
  logic [N-1:0] q;
  logic [N-1:0] d;
  logic [M-1:0] cnt;
  logic [N:0]   trial;
  logic [N:0]   r_new;
  logic [N-1:0] q_new;
  logic         last_iter;

  iter_counter #(.M(M)) u_iter_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (state == INIT),
    .en    (state == SUB),
    .cnt   (cnt)
  );

  // Trial subtraction: a set sign bit means the divisor did not fit, so R is kept.
  assign trial     = r - {1'b0, d};
  assign r_new     = trial[N] ? r : trial;
  assign q_new     = {q[N-1:1], ~trial[N]};
  assign last_iter = (cnt == M'(N - 1));

  assign BUSY   = (state == INIT) || (state == SHIFT) || (state == SUB);
  assign FINDIV = (state == NOTIFY);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = START ? INIT : IDLE;
      INIT:    state_nxt = (DIVISOR == '0) ? NOTIFY : SHIFT;
      SHIFT:   state_nxt = SUB;
      SUB:     state_nxt = last_iter ? NOTIFY : SHIFT;
      NOTIFY:  state_nxt = START ? NOTIFY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r         <= '0;
      q         <= '0;
      d         <= '0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      DIV_ZERO  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          r        <= '0;
          q        <= DIVIDEND;
          d        <= DIVISOR;
          DIV_ZERO <= 1'b0;
          if (DIVISOR == '0) begin
            DIV_ZERO  <= 1'b1;
            QUOTIENT  <= '1;
            REMAINDER <= DIVIDEND;
          end
        end
        SHIFT: begin
          {r, q} <= {r[N-1:0], q, 1'b0};
        end
        SUB: begin
          r <= r_new;
          q <= q_new;
          if (last_iter) begin
            QUOTIENT  <= q_new;
            REMAINDER <= r_new[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - self-checking bench for restoring_divider against an arithmetic reference
module tb_restoring_divider;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [7:0] DIVIDEND;
  logic [7:0] DIVISOR;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;
  logic       BUSY;
  logic       FINDIV;
  logic       DIV_ZERO;

  int checks   = 0;
  int failures = 0;

  restoring_divider dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .BUSY      (BUSY),
    .FINDIV    (FINDIV),
    .DIV_ZERO  (DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: START pulsed one cycle; 1: START held high; 2: operands and START scrambled while busy
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int mode, output int lat);
    @(negedge CLK);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(posedge CLK);
    lat = 0;
    @(negedge CLK);
    if (mode == 0) START = 1'b0;
    if (mode == 2) START = 1'($urandom_range(0, 1));
    while (!FINDIV && lat < 60) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (mode == 2 && !FINDIV) begin
        DIVIDEND = 8'($urandom);
        DIVISOR  = 8'($urandom);
        START    = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic expect_result(input string tag, input logic [7:0] a, input logic [7:0] b, input int lat);
    int exp_q, exp_r, exp_lat;
    if (b == 0) begin
      exp_q = 255; exp_r = a; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_lat = 17;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_quotient"}, QUOTIENT, exp_q);
    check({tag, "_remainder"}, REMAINDER, exp_r);
    check({tag, "_div_zero"}, DIV_ZERO, (b == 0));
    check({tag, "_busy"}, BUSY, 0);
  endtask

  task automatic release_start();
    START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int lat;
    logic [7:0] a, b;
    logic [7:0] ops_a [4] = '{255, 5, 200, 17};
    logic [7:0] ops_b [4] = '{1, 9, 200, 4};

    RESET = 1'b0; START = 1'b0; DIVIDEND = 8'd0; DIVISOR = 8'd0;
    #1;
    check("reset_quotient", QUOTIENT, 0);
    check("reset_remainder", REMAINDER, 0);
    check("reset_busy", BUSY, 0);
    check("reset_findiv", FINDIV, 0);
    check("reset_div_zero", DIV_ZERO, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    run_div(8'd100, 8'd7, 0, lat);
    expect_result("t1_100_7", 8'd100, 8'd7, lat);
    release_start();
    check("t1_idle_findiv", FINDIV, 0);

    for (int i = 0; i < 3; i++) begin
      run_div(ops_a[i], ops_b[i], 0, lat);
      expect_result("t2_directed", ops_a[i], ops_b[i], lat);
      release_start();
    end

    run_div(8'd200, 8'd0, 0, lat);
    expect_result("t3_div0", 8'd200, 8'd0, lat);
    release_start();

    run_div(8'd100, 8'd7, 1, lat);
    expect_result("t4_hold", 8'd100, 8'd7, lat);
    repeat (10) @(negedge CLK);
    check("t4_hold_findiv", FINDIV, 1);
    check("t4_hold_quotient", QUOTIENT, 14);
    check("t4_hold_remainder", REMAINDER, 2);
    release_start();
    check("t4_back_idle", FINDIV, 0);
    run_div(ops_a[3], ops_b[3], 0, lat);
    expect_result("t4_17_4", ops_a[3], ops_b[3], lat);
    release_start();

    @(negedge CLK);
    DIVIDEND = 8'd100; DIVISOR = 8'd7; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("t5_rst_quotient", QUOTIENT, 0);
    check("t5_rst_remainder", REMAINDER, 0);
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_findiv", FINDIV, 0);
    @(negedge CLK);
    RESET = 1'b1;
    run_div(8'd100, 8'd7, 0, lat);
    expect_result("t5_after_reset", 8'd100, 8'd7, lat);
    release_start();

    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      run_div(a, b, 2, lat);
      expect_result("t6_scramble", a, b, lat);
      release_start();
    end

    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = (i % 25 == 0) ? 8'd0 : 8'($urandom);
      run_div(a, b, 0, lat);
      expect_result("t6_random", a, b, lat);
      release_start();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
